vend_change_sequencer: RTL and testbench

//  Sequencing controller for the vending credit datapath: accepts debounced coin pulses,

---
 rtl/vend_pkg.sv | 46 ++++
 rtl/vend_hopper_timer.sv | 37 +++
 rtl/vend_change_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_vend_change_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vend_pkg
//  Purpose  : Shared coin encodings, coin value table and controller state
//             encoding for the vending change sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

  // Coin codes as seen on CoinCode / ChangeCoin
  localparam logic [1:0] c_COIN_5   = 2'b00;
  localparam logic [1:0] c_COIN_10  = 2'b01;
  localparam logic [1:0] c_COIN_50  = 2'b10;
  localparam logic [1:0] c_COIN_100 = 2'b11;

  // Coin values in cents
  localparam logic [7:0] c_CENTS_5   = 8'd5;
  localparam logic [7:0] c_CENTS_10  = 8'd10;
  localparam logic [7:0] c_CENTS_50  = 8'd50;
  localparam logic [7:0] c_CENTS_100 = 8'd100;

  // Controller states, explicitly encoded
  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_IDLE     = 3'd1,
    ST_PAYING   = 3'd2,
    ST_VEND     = 3'd3,
    ST_CHG_SEL  = 3'd4,
    ST_CHG_WAIT = 3'd5,
    ST_FAULT    = 3'd6
  } state_t;

  // Coin code to value in cents
  function automatic logic [7:0] coin_value(input logic [1:0] code);
    logic [7:0] v;
    case (code)
      c_COIN_5:   v = c_CENTS_5;
      c_COIN_10:  v = c_CENTS_10;
      c_COIN_50:  v = c_CENTS_50;
      default:    v = c_CENTS_100;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_hopper_timer.sv
`default_nettype none
// ============================================================================
//  Module   : vend_hopper_timer
//  Purpose  : Hopper acknowledge watchdog. Counts enabled cycles after a
//             clear and flags expiry once HOP_TIMEOUT cycles have elapsed.
//  Revision : 1.0 - initial release
// ============================================================================
module vend_hopper_timer #(
  parameter int HOP_TIMEOUT = 1000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int                 c_CNT_W = $clog2(HOP_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(HOP_TIMEOUT);

  logic [c_CNT_W-1:0] r_cnt;

  // Count while enabled, holding at the limit so expiry stays asserted
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/vend_change_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : vend_change_sequencer
//  Purpose  : Vending credit controller. Accumulates coin credit, issues the
//             vend pulse, then pays change or refunds one coin at a time
//             through a req/ack handshake with the coin hopper.
//  Revision : 1.0 - initial release
// ============================================================================
module vend_change_sequencer #(
  parameter logic [7:0] PRICE       = 8'd125,
  parameter int         CREDIT_W    = 8,
  parameter int         HOP_TIMEOUT = 1000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                Enable,
  input  logic                CoinValid,
  input  logic [1:0]          CoinCode,
  input  logic                Cancel,
  input  logic                ChangeAck,
  output logic                Deliver,
  output logic                CoinReject,
  output logic [CREDIT_W-1:0] Credit,
  output logic                ChangeReq,
  output logic [1:0]          ChangeCoin,
  output logic                Busy,
  output logic                Fault
);

  import vend_pkg::*;

  localparam logic [CREDIT_W-1:0] c_PRICE      = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   c_CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W-1:0] c_CREDIT_10  = CREDIT_W'(c_CENTS_10);
  localparam logic [CREDIT_W-1:0] c_CREDIT_50  = CREDIT_W'(c_CENTS_50);
  localparam logic [CREDIT_W-1:0] c_CREDIT_100 = CREDIT_W'(c_CENTS_100);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_deliver;
  logic                r_coin_reject;
  logic                r_change_req;
  logic [1:0]          r_change_coin;
  logic                r_busy;
  logic                r_fault;

  logic [CREDIT_W-1:0] w_coin_in_val;
  logic [CREDIT_W-1:0] w_chg_val;
  logic [CREDIT_W:0]   w_credit_sum;
  logic                w_coin_fits;
  logic [1:0]          w_greedy_code;
  logic                w_tmr_clr;
  logic                w_tmr_en;
  logic                w_tmr_expired;

  // One extra bit on the sum so saturation is detected without wrap
  assign w_coin_in_val = CREDIT_W'(coin_value(CoinCode));
  assign w_chg_val     = CREDIT_W'(coin_value(r_change_coin));
  assign w_credit_sum  = {1'b0, r_credit} + {1'b0, w_coin_in_val};
  assign w_coin_fits   = (w_credit_sum <= c_CREDIT_MAX);

  // Greedy change: largest denomination not exceeding the remaining credit
  always_comb begin
    w_greedy_code = c_COIN_5;
    if (r_credit >= c_CREDIT_100) begin
      w_greedy_code = c_COIN_100;
    end else if (r_credit >= c_CREDIT_50) begin
      w_greedy_code = c_COIN_50;
    end else if (r_credit >= c_CREDIT_10) begin
      w_greedy_code = c_COIN_10;
    end
  end

  // Timer is held clear outside CHG_WAIT, so every wait starts from zero
  assign w_tmr_clr = (r_state != ST_CHG_WAIT);
  assign w_tmr_en  = (r_state == ST_CHG_WAIT);

  vend_hopper_timer #(
    .HOP_TIMEOUT (HOP_TIMEOUT)
  ) u_hopper_timer (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_tmr_expired)
  );

  // Controller state, credit register and all registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= ST_OFF;
      r_credit      <= '0;
      r_deliver     <= 1'b0;
      r_coin_reject <= 1'b0;
      r_change_req  <= 1'b0;
      r_change_coin <= c_COIN_5;
      r_busy        <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_deliver     <= 1'b0;
      r_coin_reject <= 1'b0;
      case (r_state)
        ST_OFF: begin
          r_coin_reject <= CoinValid;
          if (Enable) begin
            r_state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (!Enable) begin
            r_coin_reject <= CoinValid;
            r_state       <= ST_OFF;
          end else if (CoinValid) begin
            if (w_coin_fits) begin
              r_credit <= w_credit_sum[CREDIT_W-1:0];
              r_state  <= ST_PAYING;
            end else begin
              r_coin_reject <= 1'b1;
            end
          end
        end

        ST_PAYING: begin
          // Enough credit: vend now, any coin landing this cycle goes back
          if (r_credit >= c_PRICE) begin
            r_coin_reject <= CoinValid;
            r_deliver     <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ST_VEND;
          end else if (Cancel || !Enable) begin
            r_coin_reject <= CoinValid;
            if (r_credit == '0) begin
              r_state <= Enable ? ST_IDLE : ST_OFF;
            end else begin
              r_busy  <= 1'b1;
              r_state <= ST_CHG_SEL;
            end
          end else if (CoinValid) begin
            if (w_coin_fits) begin
              r_credit <= w_credit_sum[CREDIT_W-1:0];
            end else begin
              r_coin_reject <= 1'b1;
            end
          end
        end

        ST_VEND: begin
          r_coin_reject <= CoinValid;
          r_credit      <= r_credit - c_PRICE;
          if (r_credit != c_PRICE) begin
            r_state <= ST_CHG_SEL;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        ST_CHG_SEL: begin
          r_coin_reject <= CoinValid;
          if (r_credit == '0) begin
            r_busy  <= 1'b0;
            r_state <= Enable ? ST_IDLE : ST_OFF;
          end else begin
            r_change_coin <= w_greedy_code;
            r_change_req  <= 1'b1;
            r_state       <= ST_CHG_WAIT;
          end
        end

        ST_CHG_WAIT: begin
          r_coin_reject <= CoinValid;
          if (ChangeAck) begin
            r_change_req <= 1'b0;
            r_credit     <= r_credit - w_chg_val;
            r_state      <= ST_CHG_SEL;
          end else if (w_tmr_expired) begin
            r_change_req <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b1;
            r_state      <= ST_FAULT;
          end
        end

        ST_FAULT: begin
          r_coin_reject <= CoinValid;
        end

        default: begin
          r_state <= ST_OFF;
        end
      endcase
    end
  end

  assign Deliver    = r_deliver;
  assign CoinReject = r_coin_reject;
  assign Credit     = r_credit;
  assign ChangeReq  = r_change_req;
  assign ChangeCoin = r_change_coin;
  assign Busy       = r_busy;
  assign Fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_vend_change_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vend_change_sequencer
//  Purpose  : Self-checking bench for vend_change_sequencer. A coin/credit
//             reference model predicts credit, vend and change coins.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vend_change_sequencer;

  localparam int c_PRICE   = 125;
  localparam int c_TIMEOUT = 1000;
  localparam int c_MAXCRED = 255;

  logic       CLK;
  logic       RST_N;
  logic       Enable;
  logic       CoinValid;
  logic [1:0] CoinCode;
  logic       Cancel;
  logic       ChangeAck;
  logic       Deliver;
  logic       CoinReject;
  logic [7:0] Credit;
  logic       ChangeReq;
  logic [1:0] ChangeCoin;
  logic       Busy;
  logic       Fault;

  // Second instance priced at 255 so credit can approach saturation
  logic       s_valid;
  logic [1:0] s_code;
  logic       s_deliver;
  logic       s_reject;
  logic [7:0] s_credit;
  logic       s_req;
  logic [1:0] s_coin;
  logic       s_busy;
  logic       s_fault;

  int checks   = 0;
  int failures = 0;
  int m_credit = 0;

  vend_change_sequencer #(
    .PRICE       (8'd125),
    .CREDIT_W    (8),
    .HOP_TIMEOUT (c_TIMEOUT)
  ) u_dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .Enable     (Enable),
    .CoinValid  (CoinValid),
    .CoinCode   (CoinCode),
    .Cancel     (Cancel),
    .ChangeAck  (ChangeAck),
    .Deliver    (Deliver),
    .CoinReject (CoinReject),
    .Credit     (Credit),
    .ChangeReq  (ChangeReq),
    .ChangeCoin (ChangeCoin),
    .Busy       (Busy),
    .Fault      (Fault)
  );

  vend_change_sequencer #(
    .PRICE       (8'd255),
    .CREDIT_W    (8),
    .HOP_TIMEOUT (c_TIMEOUT)
  ) u_sat (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .Enable     (1'b1),
    .CoinValid  (s_valid),
    .CoinCode   (s_code),
    .Cancel     (1'b0),
    .ChangeAck  (1'b0),
    .Deliver    (s_deliver),
    .CoinReject (s_reject),
    .Credit     (s_credit),
    .ChangeReq  (s_req),
    .ChangeCoin (s_coin),
    .Busy       (s_busy),
    .Fault      (s_fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model helpers ----------------
  function automatic int val_of(input logic [1:0] c);
    int t[4];
    t = '{5, 10, 50, 100};
    return t[c];
  endfunction

  function automatic logic [1:0] code_of(input int v);
    for (int i = 0; i < 4; i++) begin
      if (val_of(2'(i)) == v) return 2'(i);
    end
    return 2'b00;
  endfunction

  function automatic int next_coin(input int amt);
    int d[4];
    d = '{100, 50, 10, 5};
    foreach (d[i]) begin
      if (d[i] <= amt) return d[i];
    end
    return 0;
  endfunction

  // ---------------- checking / stepping ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_deliver"}, Deliver, 0);
    chk({tag, "_reject"},  CoinReject, 0);
    chk({tag, "_credit"},  Credit, 0);
    chk({tag, "_req"},     ChangeReq, 0);
    chk({tag, "_coin"},    ChangeCoin, 0);
    chk({tag, "_busy"},    Busy, 0);
    chk({tag, "_fault"},   Fault, 0);
  endtask

  task automatic insert_coin(input logic [1:0] code);
    int  v;
    bit  acc;
    v   = val_of(code);
    acc = (m_credit + v <= c_MAXCRED);
    CoinValid = 1'b1;
    CoinCode  = code;
    tick();
    CoinValid = 1'b0;
    if (acc) m_credit += v;
    chk("coin_reject", CoinReject, !acc);
    chk("credit_after_coin", Credit, m_credit);
  endtask

  // Pay out m_credit one coin at a time, with random ack delays and stray coins
  task automatic do_change();
    int         n;
    int         d;
    int         exp_v;
    logic [1:0] exp_c;
    bit         pulse;
    while (m_credit > 0) begin
      n = 0;
      while (ChangeReq !== 1'b1 && n < 8) begin
        tick();
        n++;
      end
      chk("chg_req_seen", ChangeReq, 1);
      if (ChangeReq !== 1'b1) return;
      exp_v = next_coin(m_credit);
      exp_c = code_of(exp_v);
      chk("chg_coin", ChangeCoin, exp_c);
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        pulse     = 1'($urandom_range(0, 1));
        CoinValid = pulse;
        CoinCode  = 2'($urandom_range(0, 3));
        tick();
        CoinValid = 1'b0;
        chk("chg_hold_req", ChangeReq, 1);
        chk("chg_hold_coin", ChangeCoin, exp_c);
        chk("reject_in_change", CoinReject, pulse);
        chk("credit_hold", Credit, m_credit);
      end
      ChangeAck = 1'b1;
      tick();
      ChangeAck = 1'b0;
      m_credit -= exp_v;
      chk("req_drop", ChangeReq, 0);
      chk("credit_after_ack", Credit, m_credit);
      chk("busy_in_change", Busy, 1);
    end
    tick();
    chk("busy_done", Busy, 0);
    chk("credit_done", Credit, 0);
    chk("req_done", ChangeReq, 0);
  endtask

  // Called on the cycle the sufficient credit first becomes visible
  task automatic vend_flow(input bit drop_en);
    tick();
    chk("deliver_pulse", Deliver, 1);
    chk("busy_vend", Busy, 1);
    chk("credit_in_vend", Credit, m_credit);
    if (drop_en) Enable = 1'b0;
    tick();
    m_credit -= c_PRICE;
    chk("deliver_once", Deliver, 0);
    chk("credit_after_vend", Credit, m_credit);
    if (m_credit > 0) begin
      do_change();
    end else begin
      chk("busy_after_vend", Busy, 0);
      chk("no_chg_req", ChangeReq, 0);
    end
  endtask

  task automatic cancel_flow();
    Cancel = 1'b1;
    tick();
    Cancel = 1'b0;
    chk("busy_cancel", Busy, 1);
    chk("no_deliver_cancel", Deliver, 0);
    do_change();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int         n;
    int         n_req;
    int         ms_credit;
    bit         acc;
    bit         cancel_it;
    logic [1:0] sat_codes[5];

    RST_N     = 1'b0;
    Enable    = 1'b0;
    CoinValid = 1'b0;
    CoinCode  = 2'b00;
    Cancel    = 1'b0;
    ChangeAck = 1'b0;
    s_valid   = 1'b0;
    s_code    = 2'b00;

    tick();
    tick();
    chk_all_zero("reset");
    RST_N  = 1'b1;
    Enable = 1'b1;
    tick();
    chk("idle_busy", Busy, 0);

    // Saturation near full scale on the 255-priced instance
    sat_codes = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    ms_credit = 0;
    for (int i = 0; i < 5; i++) begin
      acc     = (ms_credit + val_of(sat_codes[i]) <= c_MAXCRED);
      s_code  = sat_codes[i];
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      if (acc) ms_credit += val_of(sat_codes[i]);
      chk("sat_reject", s_reject, !acc);
      chk("sat_credit", s_credit, ms_credit);
    end

    // Exact price: 100,10,10,5
    insert_coin(2'b11);
    insert_coin(2'b01);
    insert_coin(2'b01);
    insert_coin(2'b00);
    vend_flow(1'b0);

    // Overpay 100,50 -> change 10,10,5
    insert_coin(2'b11);
    insert_coin(2'b10);
    vend_flow(1'b0);

    // Refund 50 then 10
    insert_coin(2'b10);
    insert_coin(2'b01);
    cancel_flow();

    // Cancel wins over a simultaneous coin
    insert_coin(2'b10);
    CoinValid = 1'b1;
    CoinCode  = 2'b11;
    Cancel    = 1'b1;
    tick();
    CoinValid = 1'b0;
    Cancel    = 1'b0;
    chk("cancel_coin_reject", CoinReject, 1);
    chk("cancel_coin_credit", Credit, m_credit);
    do_change();

    // Enable dropped during change is deferred; machine then goes off
    insert_coin(2'b11);
    insert_coin(2'b10);
    vend_flow(1'b1);
    CoinValid = 1'b1;
    CoinCode  = 2'b10;
    tick();
    CoinValid = 1'b0;
    chk("off_reject", CoinReject, 1);
    chk("off_credit", Credit, 0);
    Enable = 1'b1;
    tick();

    // Random purchases and refunds
    repeat (20) begin
      cancel_it = ($urandom_range(0, 3) == 0);
      while (m_credit < c_PRICE) begin
        if (cancel_it && m_credit > 0 && $urandom_range(0, 1) == 1) break;
        insert_coin(2'($urandom_range(0, 3)));
      end
      if (m_credit >= c_PRICE) vend_flow(1'b0);
      else cancel_flow();
    end

    // Hopper timeout
    insert_coin(2'b10);
    Cancel = 1'b1;
    tick();
    Cancel = 1'b0;
    n     = 0;
    n_req = 0;
    while (Fault !== 1'b1 && n < c_TIMEOUT + 20) begin
      tick();
      if (ChangeReq === 1'b1) n_req++;
      n++;
    end
    chk("fault_set", Fault, 1);
    chk("timeout_len_ok", (n_req >= c_TIMEOUT && n_req <= c_TIMEOUT + 1), 1);
    chk("fault_req", ChangeReq, 0);
    chk("fault_busy", Busy, 0);
    chk("fault_credit", Credit, m_credit);
    CoinValid = 1'b1;
    CoinCode  = 2'b01;
    tick();
    CoinValid = 1'b0;
    chk("fault_reject", CoinReject, 1);
    chk("fault_credit_frozen", Credit, m_credit);
    tick();
    chk("fault_sticky", Fault, 1);
    RST_N = 1'b0;
    #2;
    chk_all_zero("fault_reset");
    m_credit = 0;
    tick();
    RST_N = 1'b1;
    tick();

    // Reset in the middle of a change handshake
    insert_coin(2'b11);
    insert_coin(2'b10);
    tick();
    chk("mid_deliver", Deliver, 1);
    tick();
    tick();
    chk("mid_req", ChangeReq, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    m_credit = 0;
    tick();
    RST_N = 1'b1;
    tick();
    insert_coin(2'b00);
    chk("after_reset_busy", Busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
